// File: rtl/mips_mem_arbiter.sv
// ============================================================================
// Module      : mips_mem_arbiter
// Description : Shares one unified memory port between instruction fetch (I)
//               and load/store (D). D has priority; a burst counter forces an I
//               grant after DATA_BURST_MAX back-to-back D grants.
//               Optional macro MEM_TIMEOUT_EN adds a BUSY-state abort timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int DATA_BURST_MAX = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err
);

    localparam int          BE_W        = DATA_W / 8;
    localparam logic [3:0]  C_BURST_MAX = 4'(DATA_BURST_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_done;
    logic                w_abort;
    logic [DATA_W-1:0]   w_rdata;

    logic                r_mem_valid;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_i_ack;
    logic                r_d_ack;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_is_d;
    logic [3:0]          r_cnt;

`ifdef MEM_TIMEOUT_EN
    localparam int                  TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]    C_TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0]   C_ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    logic             w_tmo_hit;

    assign w_tmo_hit = (r_tmo == C_TMO_LAST);
    assign w_rdata   = w_abort ? C_ABORT_DATA : mem_rdata;
    assign err       = r_err;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_grant_d || w_grant_i) begin
                r_tmo <= '0;
            end else if (r_state == S_BUSY) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_tmo_hit;
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_rdata      = mem_rdata;
    assign err          = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Starvation guard: once the D run hits the limit with I waiting, I goes first.
                if (d_req && !(i_req && (r_cnt == C_BURST_MAX))) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY;
                end else if (i_req) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_ACK;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_is_d      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            if (w_grant_d) begin
                r_mem_valid <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_be    <= d_be;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_is_d      <= 1'b1;
                if (!i_req) begin
                    r_cnt <= '0;
                end else if (r_cnt != C_BURST_MAX) begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
            if (w_grant_i) begin
                r_mem_valid <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= '0;
                r_is_d      <= 1'b0;
                r_cnt       <= '0;
            end
            if (w_done || w_abort) begin
                r_mem_valid <= 1'b0;
                if (r_is_d) begin
                    r_d_ack <= 1'b1;
                    if (!r_mem_we) begin
                        r_d_rdata <= w_rdata;
                    end
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= w_rdata;
                end
            end
        end
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
// ============================================================================
// Module      : tb_mips_mem_arbiter
// Description : Self-checking bench for mips_mem_arbiter with a transaction-level
//               reference model of grant order and returned data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_arbiter;

    localparam int BURST = 4;
    localparam int TMO   = 8;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    int          n_vec = 0;
    int          n_err = 0;
    int          streak = 0;
    logic [31:0] exp_ird = '0;
    logic [31:0] exp_drd = '0;
    logic        last_obs_d = 1'b0;

    mips_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .DATA_BURST_MAX(BURST), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_i();
        i_req  = 1'b1;
        i_addr = {$urandom} & 32'hFFFF_FFFC;
    endtask

    task automatic new_d(input bit store);
        d_req   = 1'b1;
        d_we    = store;
        d_be    = store ? 4'($urandom_range(1, 15)) : 4'hF;
        d_addr  = {$urandom} | 32'h1;
        d_wdata = store ? $urandom : 32'h0;
    endtask

    // Runs one transaction starting with the DUT idle and requests already driven.
    task automatic do_xact(input int lat, input logic [31:0] rd, input bit drop);
        bit          g_d;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        logic        e_we;
        g_d = d_req && !(i_req && streak >= BURST);
        if (g_d) begin
            e_addr = d_addr; e_we = d_we; e_be = d_be; e_wd = d_wdata;
            streak = i_req ? ((streak < BURST) ? streak + 1 : BURST) : 0;
        end else begin
            e_addr = i_addr; e_we = 1'b0; e_be = 4'hF; e_wd = 32'h0;
            streak = 0;
        end
        cyc();
        chk("grant_valid", mem_valid, 1);
        chk("grant_addr", mem_addr, e_addr);
        chk("grant_we", mem_we, e_we);
        chk("grant_be", mem_be, e_be);
        chk("grant_wdata", mem_wdata, e_wd);
        if (drop) begin
            if (g_d) d_req = 1'b0; else i_req = 1'b0;
        end
        for (int k = 0; k < lat; k++) begin
            cyc();
            chk("busy_valid", mem_valid, 1);
            chk("busy_hold", {mem_addr, mem_wdata}, {e_addr, e_wd});
            chk("busy_hold_ctl", {mem_we, mem_be}, {e_we, e_be});
            chk("busy_noack", {i_ack, d_ack}, 2'b00);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        cyc();
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (g_d && !e_we) exp_drd = rd;
        if (!g_d) exp_ird = rd;
        last_obs_d = d_ack;
        chk("ack_valid_low", mem_valid, 0);
        chk("ack_which", {i_ack, d_ack}, g_d ? 2'b01 : 2'b10);
        chk("ack_i_rdata", i_rdata, exp_ird);
        chk("ack_d_rdata", d_rdata, exp_drd);
        if (g_d) d_req = 1'b0; else i_req = 1'b0;
        cyc();
        chk("post_ack_low", {i_ack, d_ack, mem_valid}, 3'b000);
    endtask

    initial begin
        bit exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        // Reset state
        #12;
        chk("rst_ctl", {mem_valid, mem_we, i_ack, d_ack, err}, 5'b0);
        chk("rst_bus", {mem_be, mem_addr, mem_wdata}, 68'h0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        @(posedge CLK);
        #1 Reset = 1'b0;
        cyc();

        // Directed fetch
        i_req = 1'b1;
        i_addr = 32'h0040_0000;
        do_xact(2, 32'h2008_0005, 1'b0);
        chk("fetch_rdata", i_rdata, 32'h2008_0005);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        cyc();
        cyc();
        chk("idle_ready_ign", {mem_valid, i_ack, d_ack}, 3'b000);
        mem_ready = 1'b0;
        cyc();

        // Directed store
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3;
        d_addr = 32'h1001_0004; d_wdata = 32'h0000_ABCD;
        do_xact(3, 32'h5555_AAAA, 1'b0);
        chk("store_drd_kept", d_rdata, 32'h0);

        // Both held: D,D,D,D,I,D,D,D,D,I
        for (int k = 0; k < 10; k++) begin
            if (!i_req) new_i();
            if (!d_req) new_d($urandom_range(0, 1) == 1);
            do_xact($urandom_range(0, 2), $urandom, 1'b0);
            chk($sformatf("burst_order_%0d", k), last_obs_d, exp_seq[k]);
        end

        // Reset during BUSY clears the burst run
        for (int k = 0; k < 3; k++) begin
            if (!i_req) new_i();
            if (!d_req) new_d(1'b0);
            do_xact(1, $urandom, 1'b0);
        end
        if (!i_req) new_i();
        if (!d_req) new_d(1'b0);
        cyc();
        chk("pre_rst_valid", mem_valid, 1);
        Reset = 1'b1;
        #1;
        chk("rst_busy_valid", mem_valid, 0);
        cyc();
        chk("rst_busy_noack", {i_ack, d_ack}, 2'b00);
        Reset = 1'b0;
        streak = 0;
        exp_ird = '0;
        exp_drd = '0;
        for (int k = 0; k < 5; k++) begin
            if (!i_req) new_i();
            if (!d_req) new_d(1'b0);
            do_xact(0, $urandom, 1'b0);
            chk($sformatf("post_rst_order_%0d", k), last_obs_d, (k < 4) ? 1'b1 : 1'b0);
        end

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if (!i_req && $urandom_range(0, 1) == 1) new_i();
            if (!d_req && $urandom_range(0, 1) == 1) new_d($urandom_range(0, 1) == 1);
            if (!i_req && !d_req) begin
                if ($urandom_range(0, 1) == 1) new_i(); else new_d($urandom_range(0, 1) == 1);
            end
            do_xact($urandom_range(0, 3), $urandom, $urandom_range(0, 4) == 0);
        end

`ifdef MEM_TIMEOUT_EN
        i_req = 1'b0;
        d_req = 1'b0;
        cyc();
        new_i();
        cyc();
        streak = 0;
        for (int k = 0; k < TMO - 1; k++) begin
            cyc();
            chk("tmo_wait_valid", mem_valid, 1);
        end
        cyc();
        chk("tmo_abort", {mem_valid, err, i_ack, d_ack}, 4'b0110);
        chk("tmo_rdata", i_rdata, 32'hDEAD_BEEF);
        exp_ird = 32'hDEAD_BEEF;
        i_req = 1'b0;
        cyc();
        new_d(1'b0);
        do_xact(1, $urandom, 1'b0);
        chk("tmo_err_sticky", err, 1);
`else
        chk("err_tied", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
